mult_unit: RTL and testbench

- Iterative RV32M multiplier in the EXECUTE stage. Executes MUL, MULH, MULHSU and MULHU.
- Produces `mult_ready`, which the hazard unit consumes. While a multiply sits in EX and `mult_ready` is low, the hazard unit holds fetch, decode and execute, and feeds memory a bubble.
- Latches operands at issue and iterates a shift-add over magnitudes. Applies the sign at the end and holds the result until the pipeline advances.

---
 rtl/mult_unit.sv | 127 ++++++++++++
 tb/tb_mult_unit.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/mult_unit.sv
//=== mult_unit: iterative RV32M multiplier (MUL, MULH, MULHSU, MULHU) ===
// Revision: 1.0 - initial release
`default_nettype none

module mult_unit #(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        advance,
  input  logic        flush,
  output logic        mult_ready,
  output logic [31:0] result
);

  localparam int ITER = 32 / BITS_PER_CYCLE;
  localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] BUSY = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;

  logic [1:0]    state;
  logic [1:0]    op_q;
  logic          neg_q;
  logic [63:0]   mcand;
  logic [32:0]   mplier;
  logic [63:0]   acc;
  logic [CW-1:0] cnt;
  logic [31:0]   result_q;

  logic          sa;
  logic          sb;
  logic [32:0]   a_ext;
  logic [32:0]   b_ext;
  logic [32:0]   mag_a;
  logic [32:0]   mag_b;
  logic [63:0]   step_sum;
  logic [63:0]   product;

  // Sign-extend to 33 bits only for signed operands; the negation of
  // -2^31 then lands exactly on 0x0_8000_0000.
  always_comb begin
    sa    = a[31] & ((op == OP_MULH) | (op == OP_MULHSU));
    sb    = b[31] & (op == OP_MULH);
    a_ext = {sa, a};
    b_ext = {sb, b};
    mag_a = a_ext[32] ? (33'd0 - a_ext) : a_ext;
    mag_b = b_ext[32] ? (33'd0 - b_ext) : b_ext;
  end

  always_comb begin
    step_sum = acc;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (mplier[i]) begin
        step_sum = step_sum + (mcand << i);
      end
    end
    product = neg_q ? (64'd0 - step_sum) : step_sum;
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state    <= IDLE;
      op_q     <= 2'b00;
      neg_q    <= 1'b0;
      mcand    <= 64'd0;
      mplier   <= 33'd0;
      acc      <= 64'd0;
      cnt      <= '0;
      result_q <= 32'd0;
    end else if (flush) begin
      state <= IDLE;
      acc   <= 64'd0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_q   <= op;
            neg_q  <= sa ^ sb;
            mcand  <= {31'd0, mag_a};
            mplier <= mag_b;
            acc    <= 64'd0;
            cnt    <= '0;
            if ((a == 32'd0) || (b == 32'd0)) begin
              result_q <= 32'd0;
              state    <= DONE;
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          acc    <= step_sum;
          mcand  <= mcand << BITS_PER_CYCLE;
          mplier <= mplier >> BITS_PER_CYCLE;
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(ITER - 1)) begin
            result_q <= (op_q == OP_MUL) ? product[31:0] : product[63:32];
            state    <= DONE;
          end
        end
        DONE: begin
          if (advance) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mult_ready = (state == DONE);
  assign result     = result_q;

endmodule

`default_nettype wire

// File: tb/tb_mult_unit.sv
//=== tb_mult_unit: directed self-checking bench for mult_unit ===
// Revision: 1.0 - initial release
`default_nettype none

module tb_mult_unit;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        advance;
  logic        flush;
  logic        mult_ready;
  logic [31:0] result;

  logic        start4;
  logic [1:0]  op4;
  logic [31:0] a4;
  logic [31:0] b4;
  logic        advance4;
  logic        flush4;
  logic        mult_ready4;
  logic [31:0] result4;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  mult_unit #(.BITS_PER_CYCLE(1)) dut1 (
    .CLK(CLK), .nRST(nRST), .start(start), .op(op), .a(a), .b(b),
    .advance(advance), .flush(flush), .mult_ready(mult_ready), .result(result)
  );

  mult_unit #(.BITS_PER_CYCLE(4)) dut4 (
    .CLK(CLK), .nRST(nRST), .start(start4), .op(op4), .a(a4), .b(b4),
    .advance(advance4), .flush(flush4), .mult_ready(mult_ready4), .result(result4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // A multiply in progress must keep start high unless it is being flushed.
  always @(negedge CLK) begin
    if (nRST && (dut1.state == 2'b01) && !start && !flush) begin
      errors++;
      $display("FAIL start_drop: start=0 while busy at time %0t", $time);
    end
  end

  // Issue one op, scramble operands while busy, and check latency and result.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] exp_res,
                        input int exp_lat, input bit release_done);
    int n;
    bit got;
    @(negedge CLK);
    start = 1'b1; op = o; a = x; b = y; advance = 1'b0;
    n = 0;
    got = 1'b0;
    while (!got && n < 100) begin
      @(posedge CLK); #1;
      n++;
      if (mult_ready) got = 1'b1;
      else begin
        a  = ~x;
        b  = y ^ 32'h5A5A_A5A5;
        op = ~o;
      end
    end
    check({tag, "_lat"}, 32'(n), 32'(exp_lat));
    check({tag, "_res"}, result, exp_res);
    if (release_done) begin
      @(negedge CLK);
      advance = 1'b1; start = 1'b0;
      @(posedge CLK); #1;
      check({tag, "_rel"}, {31'd0, mult_ready}, 32'd0);
      @(negedge CLK);
      advance = 1'b0;
    end
  endtask

  initial begin
    int n;
    nRST = 1'b0; start = 1'b0; op = 2'b00; a = 32'd0; b = 32'd0;
    advance = 1'b0; flush = 1'b0;
    start4 = 1'b0; op4 = 2'b00; a4 = 32'd0; b4 = 32'd0;
    advance4 = 1'b0; flush4 = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("reset_ready", {31'd0, mult_ready}, 32'd0);
    check("reset_result", result, 32'd0);
    @(negedge CLK);
    nRST = 1'b1;

    run_op("mul_7x6",      2'b00, 32'd7,         32'd6,         32'd42,        33, 1'b1);
    run_op("mulh_min_sq",  2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, 1'b1);
    run_op("mul_min_sq",   2'b00, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 33, 1'b1);
    run_op("mulhsu_m1",    2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 1'b1);
    run_op("mulhu_max",    2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 1'b1);
    run_op("mul_zero_a",   2'b00, 32'd0,         32'h1234_5678, 32'd0,         1,  1'b1);
    run_op("mulh_zero_b",  2'b01, 32'hFFFF_FFF0, 32'd0,         32'd0,         1,  1'b1);
    run_op("mulh_neg",     2'b01, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 33, 1'b1);
    run_op("mulhu_2p32",   2'b11, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 33, 1'b1);

    // Wider-step instance: same 7 x 6 finishes after ITER = 8 busy cycles.
    @(negedge CLK);
    start4 = 1'b1; op4 = 2'b00; a4 = 32'd7; b4 = 32'd6;
    n = 0;
    while (!mult_ready4 && n < 100) begin
      @(posedge CLK); #1;
      n++;
    end
    check("mul4_lat", 32'(n), 32'd9);
    check("mul4_res", result4, 32'd42);
    @(negedge CLK);
    start4 = 1'b0; advance4 = 1'b1;
    @(negedge CLK);
    advance4 = 1'b0;

    // Flush on busy cycle 10 discards the op; the next one must be clean.
    @(negedge CLK);
    start = 1'b1; op = 2'b00; a = 32'd100; b = 32'd100;
    repeat (10) @(posedge CLK);
    @(negedge CLK);
    flush = 1'b1; start = 1'b0;
    @(posedge CLK); #1;
    check("flush_ready", {31'd0, mult_ready}, 32'd0);
    @(negedge CLK);
    flush = 1'b0;
    run_op("mul_after_flush", 2'b00, 32'd3, 32'd5, 32'd15, 33, 1'b1);

    // Downstream stall: DONE held with advance low.
    run_op("mul_neg_hold", 2'b00, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 33, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK); #1;
      check("hold_ready", {31'd0, mult_ready}, 32'd1);
      check("hold_result", result, 32'hFFFF_FFF1);
    end
    @(negedge CLK);
    advance = 1'b1; start = 1'b0;
    @(negedge CLK);
    advance = 1'b0;

    // Reset in the middle of a multiply.
    @(negedge CLK);
    start = 1'b1; op = 2'b00; a = 32'd9; b = 32'd9;
    repeat (5) @(posedge CLK);
    @(negedge CLK);
    nRST = 1'b0; start = 1'b0;
    @(posedge CLK); #1;
    check("rst_mid_ready", {31'd0, mult_ready}, 32'd0);
    check("rst_mid_result", result, 32'd0);
    @(negedge CLK);
    nRST = 1'b1;
    run_op("mul_after_rst", 2'b00, 32'd9, 32'd9, 32'd81, 33, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
